mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port arbiter that shares a single-port, one-cycle-latency word SRAM (`picosoc_mem`-style: registered `rdata`, byte write enables) between two native-memory-interface requesters: port 0 (CPU) and port 1 (loader/debug master). It sits between the requesters and the SRAM.
- Serialises accesses with a round-robin grant.
- Returns `mem_ready` with the correct read data.
- Blocks out-of-range accesses so they never alias into the SRAM.

## Interface
Parameters:
- `WORDS`, 32, SRAM depth in 32-bit words; power of two, at least 2.
- `AW`, `$clog2(WORDS)`, SRAM word-address width; derived, not overridden.

Ports (clock is `clk`; reset is `reset`, asynchronous and active-high):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `p0_valid`, `p1_valid` in 1: request valid; held until the matching ready.
- `p0_addr`, `p1_addr` in 32: byte address; bits [1:0] ignored.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_wstrb`, `p1_wstrb` in 4: byte strobes; 0 means read.
- `p0_ready`, `p1_ready` out 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out 32: read data, valid while the matching ready is 1.
- `p0_err`, `p1_err` out 1: out-of-range flag, pulses with ready.
- `sram_wen` out 4: SRAM byte write enables.
- `sram_addr` out AW: SRAM word address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM registered read data; one-cycle latency.

## Operation
- Requester contract:
  - Once valid is raised, addr, wdata and wstrb are held stable until ready.
  - Valid drops or changes request only after the ready cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the port selected by the priority pointer `prio` (reset value 0).
  - On a grant: register `gnt_id`, go to ISSUE.
- ISSUE:
  - `sram_addr` = granted `addr[AW+1:2]`; `sram_wdata` = granted wdata.
  - `sram_wen` = granted wstrb if in range, else 4'b0.
  - Register `oor` = (granted `addr[31:AW+2]` != 0). Go to RESP.
- RESP:
  - Pulse granted `pN_ready`.
  - `pN_rdata` = `sram_rdata`, or 32'h0 if `oor`.
  - `pN_err` = `oor`.
  - Set `prio` to the non-granted port. Go to IDLE.
- `sram_wen` is 4'b0 in every state except ISSUE. A write never occurs in IDLE or RESP.
- The non-granted port's ready and err stay 0. Its rdata is 32'h0 whenever its ready is 0.
- In ISSUE, `sram_addr` reflects the granted port. In IDLE and RESP it holds its last value; tests must not depend on this value.
- Reads with wstrb = 0 still drive a valid `sram_addr`. A partial wstrb writes only the strobed bytes. Read data in RESP of a write transaction is don't-care, but is still driven from `sram_rdata`.

## Timing
- Latency: a valid sampled in IDLE at edge N gives ready high in cycle N+2.
- Throughput: at most one transaction every 3 cycles.
- Under sustained contention from both ports, grants alternate 0,1,0,1… No port waits more than one foreign transaction (3 cycles).
- A valid that rises during ISSUE or RESP is considered at the next IDLE.
- `reset` asserted mid-transaction, immediately and asynchronously:
  - State goes to IDLE, `prio` to 0, `gnt_id` to 0, `oor` to 0.
  - `sram_wen` goes to 0, all ready and err outputs to 0, all rdata to 0.
  - An aborted write may or may not have reached the SRAM. Requesters must reissue.
- Reset values of outputs: `sram_wen` 0, `sram_addr` 0, `sram_wdata` 0, all ready, err and rdata 0.

## Structure
- Package `mem_arb_pkg`:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - Port-id constants: PORT_CPU=1'b0, PORT_AUX=1'b1.
- Sub-module `rr_arb2`: two-request round-robin picker.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: `gnt_valid`, `gnt_id`.
  - Purely combinational.
  - The FSM owns the `prio` register.
- Everything else lives in `mem_port_arbiter`: FSM, per-port mux/demux, range check.

## Test plan
- Single read:
  - Stimulus: preload `mem[3]` = 32'hDEADBEEF; `p0_valid` with `p0_addr` = 32'h0C, wstrb 0 at cycle 0.
  - Response: `p0_ready` = 1 at cycle 2, `p0_rdata` = 32'hDEADBEEF, `p0_err` = 0.
- Byte write:
  - Stimulus: `p1` writes `wdata` = 32'h11223344, wstrb 4'b0010 to addr 32'h10 holding 32'h0; then `p1` reads addr 32'h10.
  - Response: `sram_wen` = 4'b0010 only in ISSUE; read returns 32'h00003300.
- Contention:
  - Stimulus: both valid continuously for 4 transactions from reset.
  - Response: grant order 0,1,0,1; readies at cycles 2,5,8,11.
- Out of range (WORDS = 32):
  - Stimulus: `p0` writes addr 32'h80; then reads addr 32'h80.
  - Response: `sram_wen` stays 0 throughout; `mem[0]` is unchanged; read gives rdata 0 with `p0_err` = 1 together with ready.
- Reset mid-op:
  - Stimulus: assert `reset` during ISSUE of a `p1` read.
  - Response: all outputs go to 0 asynchronously, with no ready pulse. After release, a fresh `p0` request completes in 2 cycles, since `prio` is back to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StResp  = RESP
  } arb_state_e;

  // True when any byte-address bit above the SRAM word index is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 32'd2)) != 32'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request round-robin picker; the caller owns the priority pointer.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    if (req[1] && (!req[0] || prio == PORT_AUX)) begin
      gnt_id = PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a one-cycle-latency word SRAM between two native-memory requesters,
// one transaction at a time, with round-robin grant and out-of-range blocking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORDS = 32,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_valid,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_wstrb,
  output logic          p0_ready,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_valid,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_wstrb,
  output logic          p1_ready,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  arb_state_e state_q;
  logic       gnt_q;
  logic       prio_q;
  logic       oor_q;

  logic        pick_valid;
  logic        pick_id;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [3:0]  pick_wstrb;
  logic [31:0] gnt_addr;

  rr_arb2 u_rr_arb2 (
    .req       ({p1_valid, p0_valid}),
    .prio      (prio_q),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  always_comb begin
    pick_addr  = (pick_id == PORT_AUX) ? p1_addr  : p0_addr;
    pick_wdata = (pick_id == PORT_AUX) ? p1_wdata : p0_wdata;
    pick_wstrb = (pick_id == PORT_AUX) ? p1_wstrb : p0_wstrb;
    gnt_addr   = (gnt_q == PORT_AUX)   ? p1_addr  : p0_addr;
  end

  // SRAM-side outputs are loaded on the grant edge so they are valid for the whole ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= PORT_CPU;
      prio_q     <= PORT_CPU;
      oor_q      <= 1'b0;
      sram_wen   <= 4'b0;
      sram_addr  <= '0;
      sram_wdata <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          sram_wen <= 4'b0;
          if (pick_valid) begin
            gnt_q      <= pick_id;
            sram_addr  <= pick_addr[AW+1:2];
            sram_wdata <= pick_wdata;
            sram_wen   <= addr_oor(pick_addr, AW) ? 4'b0 : pick_wstrb;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          oor_q    <= addr_oor(gnt_addr, AW);
          sram_wen <= 4'b0;
          state_q  <= StResp;
        end
        StResp: begin
          sram_wen <= 4'b0;
          prio_q   <= ~gnt_q;
          state_q  <= StIdle;
        end
        default: begin
          sram_wen <= 4'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  // Response side is a decode of registered state; rdata passes the SRAM's registered word.
  always_comb begin
    p0_ready = (state_q == StResp) && (gnt_q == PORT_CPU);
    p1_ready = (state_q == StResp) && (gnt_q == PORT_AUX);
    p0_err   = p0_ready && oor_q;
    p1_err   = p1_ready && oor_q;
    p0_rdata = (p0_ready && !oor_q) ? sram_rdata : 32'h0;
    p1_rdata = (p1_ready && !oor_q) ? sram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned WORDS = 32;
  localparam int unsigned AW    = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_ready, p1_ready, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  // Requests, indexed by port.
  logic        req_v [2];
  logic [31:0] req_a [2];
  logic [31:0] req_d [2];
  logic [3:0]  req_s [2];

  logic [31:0] sram_mem  [WORDS];
  logic [31:0] model_mem [WORDS];
  logic        model_prio;
  logic        bk_en;
  logic [AW-1:0] bk_idx;
  logic [31:0] bk_val;
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  int          n_cmp, n_err;

  assign p0_valid = req_v[0];
  assign p0_addr  = req_a[0];
  assign p0_wdata = req_d[0];
  assign p0_wstrb = req_s[0];
  assign p1_valid = req_v[1];
  assign p1_addr  = req_a[1];
  assign p1_wdata = req_d[1];
  assign p1_wstrb = req_s[1];

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_valid   (p0_valid),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_wstrb   (p0_wstrb),
    .p0_ready   (p0_ready),
    .p0_rdata   (p0_rdata),
    .p0_err     (p0_err),
    .p1_valid   (p1_valid),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_wstrb   (p1_wstrb),
    .p1_ready   (p1_ready),
    .p1_rdata   (p1_rdata),
    .p1_err     (p1_err),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM with registered read data and a backdoor preload.
  always @(posedge clk) begin
    if (bk_en) begin
      sram_mem[bk_idx] <= bk_val;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wen[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
    sram_rdata <= sram_mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic backdoor(input int idx, input logic [31:0] val);
    bk_en  = 1'b1;
    bk_idx = idx[AW-1:0];
    bk_val = val;
    @(negedge clk);
    bk_en = 1'b0;
    model_mem[idx] = val;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_p0_ready"}, 32'(p0_ready), 32'h0);
    check({tag, "_p1_ready"}, 32'(p1_ready), 32'h0);
    check({tag, "_p0_err"}, 32'(p0_err), 32'h0);
    check({tag, "_p1_err"}, 32'(p1_err), 32'h0);
    check({tag, "_p0_rdata"}, p0_rdata, 32'h0);
    check({tag, "_p1_rdata"}, p1_rdata, 32'h0);
    check({tag, "_sram_wen"}, 32'(sram_wen), 32'h0);
  endtask

  // Runs the pending request(s) starting from an IDLE cycle; returns at the next IDLE cycle.
  task automatic run_txn();
    int          exp_cyc [2];
    int          last;
    logic        oor [2];
    logic [3:0]  exp_wen;
    logic        rdy, obs_rdy, obs_err;
    logic [31:0] obs_rd, exp_rd;
    int          idx;
    for (int p = 0; p < 2; p++) begin
      oor[p]     = (req_a[p] >> (AW + 2)) != 32'd0;
      exp_cyc[p] = 0;
    end
    if (req_v[0] && req_v[1]) begin
      exp_cyc[model_prio]  = 2;
      exp_cyc[!model_prio] = 5;
    end else if (req_v[0]) begin
      exp_cyc[0] = 2;
    end else if (req_v[1]) begin
      exp_cyc[1] = 2;
    end
    last = (exp_cyc[0] > exp_cyc[1]) ? exp_cyc[0] : exp_cyc[1];
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_wen = 4'b0;
      for (int p = 0; p < 2; p++) begin
        if (exp_cyc[p] != 0 && c == exp_cyc[p] - 1) begin
          if (!oor[p]) exp_wen = req_s[p];
          check($sformatf("p%0d_sram_addr", p), 32'(sram_addr), 32'(req_a[p][AW+1:2]));
          check($sformatf("p%0d_sram_wdata", p), sram_wdata, req_d[p]);
        end
      end
      check($sformatf("sram_wen_c%0d", c), 32'(sram_wen), 32'(exp_wen));
      for (int p = 0; p < 2; p++) begin
        rdy     = exp_cyc[p] != 0 && c == exp_cyc[p];
        obs_rdy = (p == 0) ? p0_ready : p1_ready;
        obs_err = (p == 0) ? p0_err : p1_err;
        obs_rd  = (p == 0) ? p0_rdata : p1_rdata;
        idx     = int'(req_a[p][AW+1:2]);
        check($sformatf("p%0d_ready_c%0d", p, c), 32'(obs_rdy), 32'(rdy));
        check($sformatf("p%0d_err_c%0d", p, c), 32'(obs_err), 32'(rdy && oor[p]));
        if (!(rdy && !oor[p] && req_s[p] != 4'b0)) begin
          exp_rd = (rdy && !oor[p]) ? model_mem[idx] : 32'h0;
          check($sformatf("p%0d_rdata_c%0d", p, c), obs_rd, exp_rd);
        end
        if (rdy) begin
          last_rdata[p] = obs_rd;
          last_err[p]   = obs_err;
          if (!oor[p]) begin
            for (int b = 0; b < 4; b++) begin
              if (req_s[p][b]) model_mem[idx][8*b +: 8] = req_d[p][8*b +: 8];
            end
          end
          model_prio = (p == 0);
          req_v[p]   = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_v[p] = 1'b1;
    req_a[p] = a;
    req_d[p] = d;
    req_s[p] = s;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 5) != 0) a[31:AW+2] = '0;
    return a;
  endfunction

  initial begin
    logic [31:0] saved;
    int          sel;
    n_cmp = 0;
    n_err = 0;
    bk_en = 1'b0;
    bk_idx = '0;
    bk_val = 32'h0;
    model_prio = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0;
      req_a[p] = 32'h0;
      req_d[p] = 32'h0;
      req_s[p] = 4'b0;
      last_rdata[p] = 32'h0;
      last_err[p] = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_all_quiet("rst");
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    check("rst_sram_wdata", sram_wdata, 32'h0);
    for (int i = 0; i < int'(WORDS); i++) backdoor(i, $urandom);
    backdoor(3, 32'hDEADBEEF);
    backdoor(4, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Sustained contention from reset: grants 0,1,0,1 with readies at 2,5,8,11.
    set_req(0, 32'h0000_000C, 32'h0, 4'b0);
    set_req(1, 32'h0000_0010, 32'h0, 4'b0);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cont_p0_ready_c%0d", c), 32'(p0_ready), 32'(c == 2 || c == 8));
      check($sformatf("cont_p1_ready_c%0d", c), 32'(p1_ready), 32'(c == 5 || c == 11));
      if (c == 2 || c == 8) check("cont_p0_rdata", p0_rdata, model_mem[3]);
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    model_prio = 1'b0;
    @(negedge clk);

    set_req(0, 32'h0000_000C, 32'h0, 4'b0);
    run_txn();
    check("single_read", last_rdata[0], 32'hDEADBEEF);

    set_req(1, 32'h0000_0010, 32'h1122_3344, 4'b0010);
    run_txn();
    set_req(1, 32'h0000_0010, 32'h0, 4'b0);
    run_txn();
    check("byte_write_read", last_rdata[1], 32'h0000_3300);

    saved = model_mem[0];
    set_req(0, 32'h0000_0080, 32'hCAFE_F00D, 4'b1111);
    run_txn();
    check("oor_mem0", sram_mem[0], saved);
    set_req(0, 32'h0000_0080, 32'h0, 4'b0);
    run_txn();
    check("oor_read_err", 32'(last_err[0]), 32'h1);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        if (sel[p]) set_req(p, rand_addr(), $urandom,
                            ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15)));
      end
      run_txn();
    end

    // Leave prio pointing at port 1 so a surviving pointer would be visible after reset.
    set_req(0, 32'h0000_0004, 32'h0, 4'b0);
    run_txn();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_req(1, 32'h0000_0014, 32'h0, 4'b0);
      else        set_req(0, 32'h0000_0018, 32'hA5A5_5A5A, 4'b1111);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_all_quiet($sformatf("midrst%0d", k));
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      @(negedge clk);
      check_all_quiet($sformatf("midrst%0d_held", k));
      @(negedge clk);
      reset = 1'b0;
      model_prio = 1'b0;
      @(negedge clk);
    end
    backdoor(6, 32'h0BAD_F00D);

    set_req(0, 32'h0000_0018, 32'h0, 4'b0);
    set_req(1, 32'h0000_000C, 32'h0, 4'b0);
    run_txn();
    check("post_rst_read", last_rdata[0], 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
